// File: rtl/axi_llc_arcane_lock_arb.sv
// LLC exclusive-lock arbiter: picks a requester round-robin and steps the LLC through
// isolate -> drain -> grant -> release. Every wait phase is guarded by a timeout watchdog.
module axi_llc_arcane_lock_arb #(
  parameter  int unsigned NUM_REQ        = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned OW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [OW-1:0]      owner_o,
  output logic               busy_o,
  output logic               llc_isolate_o,
  input  logic               llc_isolated_i,
  input  logic               ar_unit_busy_i,
  input  logic               aw_unit_busy_i,
  output logic               err_o,
  input  logic               clr_err_i
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISOLATE = 3'd1,
    S_LOCKED  = 3'd2,
    S_RELEASE = 3'd3,
    S_ERR     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   winner;
  logic [TW-1:0]   timer_q;
  logic            timeout;
  logic            drained;
  int              idx;

  // Round-robin pick: scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    winner = rr_ptr_q;
    idx    = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (req_i[idx]) winner = OW'(idx);
    end
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign drained = llc_isolated_i & ~ar_unit_busy_i & ~aw_unit_busy_i;

  // Next-state decode; withdrawal by the owner always beats completion and timeout.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d = winner;
          state_d = S_ISOLATE;
        end
      end
      S_ISOLATE: begin
        if (!req_i[owner_q])  state_d = S_RELEASE;
        else if (drained)     state_d = S_LOCKED;
        else if (timeout)     state_d = S_ERR;
      end
      S_LOCKED: begin
        if (!req_i[owner_q])      state_d = S_RELEASE;
        else if (!llc_isolated_i) state_d = S_ERR;
      end
      S_RELEASE: begin
        if (!llc_isolated_i) begin
          state_d  = S_IDLE;
          rr_ptr_d = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        if (clr_err_i) state_d = S_RELEASE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointer, saturating phase timer and registered Moore outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      grant_o       <= '0;
      busy_o        <= 1'b0;
      llc_isolate_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      if (state_d != state_q)  timer_q <= '0;
      else if (timer_q != '1)  timer_q <= timer_q + 1'b1;
      grant_o       <= (state_d == S_LOCKED) ? (NUM_REQ'(1) << owner_d) : '0;
      busy_o        <= (state_d != S_IDLE);
      llc_isolate_o <= (state_d == S_ISOLATE) || (state_d == S_LOCKED) || (state_d == S_ERR);
      err_o         <= (state_d == S_ERR);
    end
  end

  assign owner_o = owner_q;

endmodule
